gradient_tx_packetizer: RTL and testbench
=========================================

GRADIENT_TX_PACKETIZER -- requirements
Module: gradient_tx_packetizer

Interface
REQ-001 Parameter FLOAT_SIZE, default 32, width of one gradient float.
REQ-002 Parameter FIFO_DEPTH, default 8, gradient entries buffered (power of 2, >=2).
REQ-003 Clock and reset: `clk` input 1, single clock; `rst` input 1, reset. One clock; reset is synchronous and active-high.
REQ-004 `session_id` input 16: TCP session for all transmissions, sampled at META entry.
REQ-005 `batch_gradient_TDATA` input 512: gradient line; only [31:0] carries data.
REQ-006 `batch_gradient_TVALID` input 1: gradient line valid.
REQ-007 `batch_gradient_TLAST` input 1: ignored.
REQ-008 `batch_gradient_TREADY` output 1: FIFO can accept.
REQ-009 `m_axis_tx_meta_TDATA` output 32: {length[31:16]=16'd64, session[15:0]}.
REQ-010 `m_axis_tx_meta_TVALID` output 1; `m_axis_tx_meta_TREADY` input 1.
REQ-011 `s_axis_tx_status_TDATA` input 64: error code in [63:62], 0 = OK.
REQ-012 `s_axis_tx_status_TVALID` input 1; `s_axis_tx_status_TREADY` output 1.
REQ-013 `m_axis_tx_data_TDATA` output 512; `m_axis_tx_data_TKEEP` output 64; `m_axis_tx_data_TLAST` output 1; `m_axis_tx_data_TVALID` output 1; `m_axis_tx_data_TREADY` input 1.
REQ-014 `sent_count` output 32: beats completed; `error_count` output 16: error statuses received.

Function
REQ-015 FIFO stores TDATA[31:0] when TVALID && TREADY; TREADY = (occupancy < FIFO_DEPTH).
REQ-016 At full occupancy TREADY SHALL be 0 even during a pop that cycle; push is not accepted that cycle.
REQ-017 Push and pop in the same cycle (not full) SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-018 FSM states IDLE, META, STATUS, DATA; all handshake outputs are decoded from state only.
REQ-019 IDLE: occupancy != 0 -> META; else stay.
REQ-020 META: meta TVALID=1, TDATA stable until accepted; on TREADY -> STATUS.
REQ-021 STATUS: status TREADY=1; on TVALID with error 0 -> DATA; with error != 0 -> error_count+1 (saturate at 16'hFFFF), next state per REQ-030/031.
REQ-022 DATA: data TVALID=1, TDATA={480'b0, FIFO head}, TKEEP=64'hFFFF_FFFF_FFFF_FFFF, TLAST=1; on TREADY pop head, sent_count+1 (wraps at 2^32), -> IDLE.
REQ-023 Latency: beat accepted into empty FIFO in IDLE at edge k -> meta TVALID high after edge k+1.
REQ-024 Status TVALID outside STATUS SHALL be ignored (TREADY=0).
REQ-025 FIFO head SHALL not change between META entry and the DATA pop.
REQ-026 Outside their states meta TVALID, data TVALID, data TLAST, status TREADY SHALL be 0; data TDATA/TKEEP unconstrained when TVALID=0.

Reset
REQ-027 On rst at a clock edge: state IDLE, FIFO empty, sent_count=0, error_count=0.
REQ-028 After reset edge: all TVALID outputs 0, status TREADY 0, batch_gradient_TREADY 1.
REQ-029 Reset mid-transaction (any state) SHALL discard the in-flight entry and all buffered entries with no further beat emitted.

Configuration
REQ-030 With GRAD_TX_RETRY_EN defined: error status -> META, same head entry retransmitted (no pop).
REQ-031 Without GRAD_TX_RETRY_EN: error status -> pop head, IDLE; sent_count unchanged.

Verification
REQ-032 Push 0x3F800000, meta TREADY/status OK/data TREADY held 1 -> meta 0x0040_xxxx with session, then one data beat [31:0]=0x3F800000, TLAST=1, sent_count=1.
REQ-033 Push 9 beats with data TREADY=0 -> 9th stalls (TREADY=0 at occupancy 8); release -> 8 beats in order, then 9th.
REQ-034 Status error=2'b01 once then OK -> retry: two meta handshakes, one data beat, error_count=1; without macro: no data beat, entry dropped, next entry sent.
REQ-035 Meta TREADY low 5 cycles -> meta TVALID and TDATA stable all 5 cycles, no status accepted.
REQ-036 Assert rst in DATA with 3 entries queued -> next cycle data TVALID=0, TREADY=1, counters 0, no beat afterwards.

Source files
------------

// File: rtl/gradient_tx_packetizer.sv
// gradient_tx_packetizer - buffers gradient floats and sends each as one meta/status/data TCP transaction.
// Optional GRAD_TX_RETRY_EN: on error status, retransmit the same head entry instead of dropping it.
module gradient_tx_packetizer #(
  parameter int FLOAT_SIZE = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  session_id,
  input  logic [511:0] batch_gradient_TDATA,
  input  logic         batch_gradient_TVALID,
  input  logic         batch_gradient_TLAST,
  output logic         batch_gradient_TREADY,
  output logic [31:0]  m_axis_tx_meta_TDATA,
  output logic         m_axis_tx_meta_TVALID,
  input  logic         m_axis_tx_meta_TREADY,
  input  logic [63:0]  s_axis_tx_status_TDATA,
  input  logic         s_axis_tx_status_TVALID,
  output logic         s_axis_tx_status_TREADY,
  output logic [511:0] m_axis_tx_data_TDATA,
  output logic [63:0]  m_axis_tx_data_TKEEP,
  output logic         m_axis_tx_data_TLAST,
  output logic         m_axis_tx_data_TVALID,
  input  logic         m_axis_tx_data_TREADY,
  output logic [31:0]  sent_count,
  output logic [15:0]  error_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, META, STATUS, DATA} state_t;

  state_t                state;
  logic [FLOAT_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [15:0]           session_q;
  logic                  push;
  logic                  pop;
  logic                  status_fire;
  logic                  status_err;
  logic                  data_fire;
  logic                  unused_ok;

  assign unused_ok = ^{batch_gradient_TLAST, batch_gradient_TDATA[511:FLOAT_SIZE],
                       s_axis_tx_status_TDATA[61:0]};

  // A full FIFO refuses pushes even while the head is being popped.
  assign batch_gradient_TREADY = (count < (AW+1)'(FIFO_DEPTH));
  assign push        = batch_gradient_TVALID && batch_gradient_TREADY;
  assign status_fire = (state == STATUS) && s_axis_tx_status_TVALID;
  assign status_err  = status_fire && (s_axis_tx_status_TDATA[63:62] != 2'b00);
  assign data_fire   = (state == DATA) && m_axis_tx_data_TREADY;

`ifdef GRAD_TX_RETRY_EN
  assign pop = data_fire;
`else
  assign pop = data_fire || status_err;
`endif

  assign m_axis_tx_meta_TVALID   = (state == META);
  assign m_axis_tx_meta_TDATA    = {16'd64, session_q};
  assign s_axis_tx_status_TREADY = (state == STATUS);
  assign m_axis_tx_data_TVALID   = (state == DATA);
  assign m_axis_tx_data_TLAST    = (state == DATA);
  assign m_axis_tx_data_TKEEP    = 64'hFFFF_FFFF_FFFF_FFFF;
  assign m_axis_tx_data_TDATA    = {{(512-FLOAT_SIZE){1'b0}}, mem[rd_ptr]};

  // Writes never target rd_ptr while entries are held, so the head stays stable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= batch_gradient_TDATA[FLOAT_SIZE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      session_q   <= '0;
      sent_count  <= '0;
      error_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (data_fire) sent_count <= sent_count + 32'd1;
      if (status_err && error_count != 16'hFFFF) error_count <= error_count + 16'd1;

      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= META;
            session_q <= session_id;
          end
        end
        META: begin
          if (m_axis_tx_meta_TREADY) state <= STATUS;
        end
        STATUS: begin
          if (status_fire) begin
            if (!status_err) begin
              state <= DATA;
            end else begin
`ifdef GRAD_TX_RETRY_EN
              state     <= META;
              session_q <= session_id;
`else
              state <= IDLE;
`endif
            end
          end
        end
        DATA: begin
          if (m_axis_tx_data_TREADY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gradient_tx_packetizer.sv
// tb/tb_gradient_tx_packetizer.sv - scoreboard bench for gradient_tx_packetizer with randomized traffic.
module tb_gradient_tx_packetizer;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  session_id;
  logic [511:0] grad_data;
  logic         grad_valid;
  logic         grad_last;
  logic         grad_ready;
  logic [31:0]  meta_data;
  logic         meta_valid;
  logic         meta_ready;
  logic [63:0]  status_data;
  logic         status_valid;
  logic         status_ready;
  logic [511:0] data_data;
  logic [63:0]  data_keep;
  logic         data_last;
  logic         data_valid;
  logic         data_ready;
  logic [31:0]  sent_count;
  logic [15:0]  error_count;

  always #5 clk = ~clk;

  gradient_tx_packetizer #(.FLOAT_SIZE(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .session_id(session_id),
    .batch_gradient_TDATA(grad_data), .batch_gradient_TVALID(grad_valid),
    .batch_gradient_TLAST(grad_last), .batch_gradient_TREADY(grad_ready),
    .m_axis_tx_meta_TDATA(meta_data), .m_axis_tx_meta_TVALID(meta_valid),
    .m_axis_tx_meta_TREADY(meta_ready),
    .s_axis_tx_status_TDATA(status_data), .s_axis_tx_status_TVALID(status_valid),
    .s_axis_tx_status_TREADY(status_ready),
    .m_axis_tx_data_TDATA(data_data), .m_axis_tx_data_TKEEP(data_keep),
    .m_axis_tx_data_TLAST(data_last), .m_axis_tx_data_TVALID(data_valid),
    .m_axis_tx_data_TREADY(data_ready),
    .sent_count(sent_count), .error_count(error_count)
  );

  int          checks = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int unsigned sent_m = 0;
  int unsigned err_m = 0;
  int unsigned meta_hs = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of accepted floats; one transaction per entry.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      sent_m = 0;
      err_m  = 0;
    end else begin
      check("grad_tready", grad_ready, exp_q.size() < DEPTH);
      check("sent_count", sent_count, sent_m);
      check("error_count", error_count, err_m);
      check("one_state", $countones({meta_valid, status_ready, data_valid}) <= 1, 1'b1);
      if (meta_valid && meta_ready) begin
        check("meta_tdata", meta_data, {16'd64, session_id});
        meta_hs++;
      end
      if (status_valid && status_ready && status_data[63:62] != 2'b00) begin
        if (err_m != 16'hFFFF) err_m++;
`ifndef GRAD_TX_RETRY_EN
        if (exp_q.size() == 0) check("drop_unexpected", 1'b1, 1'b0);
        else void'(exp_q.pop_front());
`endif
      end
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          check("data_unexpected", 1'b1, 1'b0);
        end else begin
          logic [31:0] v;
          v = exp_q.pop_front();
          check("data_tdata", data_data, {480'b0, v});
          check("data_tkeep", data_keep, {64{1'b1}});
          check("data_tlast", data_last, 1'b1);
          sent_m++;
        end
      end
      if (grad_valid && grad_ready) exp_q.push_back(grad_data[31:0]);
    end
  end

  task automatic start_push(input logic [31:0] v);
    logic [479:0] hi;
    hi = {15{32'($urandom)}};
    grad_data  = {hi, v};
    grad_valid = 1'b1;
  endtask

  task automatic finish_push();
    int k = 0;
    @(negedge clk);
    while (!grad_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("push_accept", grad_ready, 1'b1);
    @(posedge clk);
    #1 grad_valid = 1'b0;
  endtask

  task automatic wait_sent(input int unsigned n);
    int k = 0;
    while (sent_count != n && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("wait_sent", sent_count, n);
  endtask

  task automatic wait_flag(input string name, ref logic sig);
    int k = 0;
    @(negedge clk);
    while (!sig && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(name, sig, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] td;
    int unsigned base_sent;
    int unsigned base_meta;
    int          seen;
    rst = 1'b1; session_id = 16'hA5C3; grad_data = '0; grad_valid = 1'b0; grad_last = 1'b0;
    meta_ready = 1'b0; status_data = '0; status_valid = 1'b0; data_ready = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_meta_valid", meta_valid, 1'b0);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_status_ready", status_ready, 1'b0);
    check("rst_grad_ready", grad_ready, 1'b1);
    check("rst_sent", sent_count, 32'd0);

    // Single float, everything ready; also first-entry latency into META.
    @(posedge clk); #1;
    meta_ready = 1'b1; data_ready = 1'b1; status_valid = 1'b1; status_data = 64'h0;
    start_push(32'h3F80_0000);
    finish_push();
    @(negedge clk);
    check("latency_k", meta_valid, 1'b0);
    @(negedge clk);
    check("latency_k1", meta_valid, 1'b1);
    wait_sent(1);

    // Meta backpressure: valid and data held, status not taken.
    @(posedge clk); #1;
    meta_ready = 1'b0;
    start_push($urandom);
    finish_push();
    wait_flag("meta_wait", meta_valid);
    td = meta_data;
    for (int i = 0; i < 5; i++) begin
      check("meta_hold_valid", meta_valid, 1'b1);
      check("meta_hold_data", meta_data, td);
      check("meta_hold_status", status_ready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1 meta_ready = 1'b1;
    wait_sent(2);

    // Fill to depth with data stalled; ninth float must stall.
    @(posedge clk); #1 data_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      start_push($urandom);
      finish_push();
    end
    start_push(32'hDEAD_0009);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_stall", grad_ready, 1'b0);
    end
    @(posedge clk); #1 data_ready = 1'b1;
    finish_push();
    wait_sent(2 + DEPTH + 1);

    // One error status then OK.
    base_sent = sent_count; base_meta = meta_hs;
    @(posedge clk); #1 status_data = {2'b01, 62'h123};
    start_push(32'h4000_0000);
    finish_push();
    wait_flag("status_wait", status_ready);
    @(posedge clk); #1 status_data = 64'h0;
`ifndef GRAD_TX_RETRY_EN
    start_push(32'h4040_0000);
    finish_push();
`endif
    wait_sent(base_sent + 1);
    @(negedge clk);
    check("err_count_one", error_count, 16'd1);
    check("err_meta_hs", meta_hs - base_meta, 2);

    // Randomized traffic with independent ready/valid on every channel.
    @(posedge clk); #1 session_id = 16'($urandom);
    fork
      begin
        logic acc;
        for (int c = 0; c < 1500; c++) begin
          @(negedge clk);
          acc = grad_valid && grad_ready;
          @(posedge clk); #1;
          if (!grad_valid || acc) begin
            grad_valid = ($urandom % 3) != 0;
            grad_data  = {{15{32'($urandom)}}, 32'($urandom)};
          end
        end
        grad_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 1500; c++) begin
          @(posedge clk); #1;
          meta_ready   = ($urandom % 4) != 0;
          data_ready   = ($urandom % 3) != 0;
          status_valid = ($urandom % 2) != 0;
          status_data  = {(($urandom % 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 62'($urandom)};
        end
      end
    join
    meta_ready = 1'b1; data_ready = 1'b1; status_valid = 1'b1; status_data = 64'h0;
    seen = 0;
    while (exp_q.size() != 0 && seen < 400) begin
      @(negedge clk);
      seen++;
    end
    check("drain_empty", exp_q.size(), 0);

    // Reset during DATA with three floats queued: nothing more is emitted.
    @(posedge clk); #1 data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_push($urandom);
      finish_push();
    end
    wait_flag("data_wait", data_valid);
    do_reset();
    @(negedge clk);
    check("rst_mid_data_valid", data_valid, 1'b0);
    check("rst_mid_grad_ready", grad_ready, 1'b1);
    check("rst_mid_sent", sent_count, 32'd0);
    check("rst_mid_err", error_count, 16'd0);
    @(posedge clk); #1 data_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_valid || meta_valid) seen++;
    end
    check("rst_no_beat", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
